// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one buart transmitter among NUM_REQ byte streams
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_busy,
  output logic                 uart_wr,
  output logic [7:0]           tx_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 locked,
  output logic                 timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE = 2'd0, GUARD = 2'd1} state_t;
  state_t state;
  logic [IW-1:0] ptr, owner, win, j;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] idle_cnt;
  logic [NUM_REQ-1:0] cand;
  logic found, fire, inc, in_idle;
  // while locked, grant is the one-hot owner, so masking by it leaves only the owner eligible
  assign cand = locked ? req_valid & grant : req_valid;
  assign in_idle = state != GUARD;
  assign fire = (TIMEOUT != 0) && in_idle && locked && idle_cnt == TW'(TIMEOUT);
  assign inc = (TIMEOUT != 0) && in_idle && locked && !req_valid[owner];
  always_comb begin
    found = 1'b0;
    win = '0;
    j = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && cand[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      owner <= '0;
      gcnt <= '0;
      idle_cnt <= '0;
      uart_wr <= 1'b0;
      req_ready <= '0;
      tx_data <= '0;
      grant <= '0;
      locked <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      uart_wr <= 1'b0;
      req_ready <= '0;
      timeout_err <= 1'b0;
      if (!in_idle) begin
        gcnt <= gcnt == '0 ? gcnt : gcnt - 1'b1;
        if (gcnt == '0) begin
          state <= IDLE;
          grant <= locked ? grant : '0;
        end
      end else if (fire) begin
        // a stalled owner loses its lock; it rotates to lowest priority
        state <= IDLE;
        locked <= 1'b0;
        grant <= '0;
        ptr <= owner;
        timeout_err <= 1'b1;
        idle_cnt <= '0;
      end else if (!tx_busy && found) begin
        state <= GUARD;
        gcnt <= GW'(GUARD_CYCLES - 1);
        uart_wr <= 1'b1;
        req_ready <= NUM_REQ'(1) << win;
        grant <= NUM_REQ'(1) << win;
        tx_data <= req_data[{win, 3'b000} +: 8];
        locked <= ~req_last[win];
        ptr <= req_last[win] ? win : ptr;
        owner <= win;
        idle_cnt <= '0;
      end else begin
        state <= IDLE;
        idle_cnt <= inc ? idle_cnt + 1'b1 : idle_cnt;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; expected bytes are queued as stimulus is driven and matched on each uart_wr
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int G = 2;
  localparam int TO = 8;
  logic clk = 1'b0, reset = 1'b1, tx_busy = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready, grant;
  logic uart_wr, locked, timeout_err;
  logic [7:0] tx_data;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [7:0] d; int r;} exp_t;
  exp_t q[$];

  uart_tx_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_busy(tx_busy),
    .uart_wr(uart_wr), .tx_data(tx_data), .grant(grant), .locked(locked),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [7:0] d, input int r);
    exp_t e;
    e.d = d;
    e.r = r;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (uart_wr) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr: tx_data=%h req_ready=%b, required no write", tx_data, req_ready);
        end else begin
          e = q.pop_front();
          if (tx_data !== e.d || req_ready !== (N'(1) << e.r)) begin
            errors++;
            $display("FAIL scoreboard: tx_data=%h req_ready=%b, required tx_data=%h req_ready=%b",
                     tx_data, req_ready, e.d, N'(1) << e.r);
          end
        end
      end
    end
  endtask

  task automatic wait_ready(input int i, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 2000 && !ok) begin
      @(negedge clk);
      n++;
      ok = req_ready[i];
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_ready%0d: no req_ready in %0d cycles, required a pulse", i, n);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic l, input bit keep);
    bit ok;
    req_valid[i] = 1'b1;
    req_data[8*i +: 8] = d;
    req_last[i] = l;
    wait_ready(i, ok);
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({uart_wr, req_ready, tx_data, grant, locked, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_hold: wr=%b rdy=%b data=%h grant=%b locked=%b to=%b, required all 0",
               uart_wr, req_ready, tx_data, grant, locked, timeout_err);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({uart_wr, req_ready, grant, locked, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_idle: wr=%b rdy=%b grant=%b locked=%b, required all 0",
               uart_wr, req_ready, grant, locked);
    end
  endtask

  task automatic test_round_robin();
    q.push_back(mk(8'h10, 0));
    q.push_back(mk(8'h11, 1));
    q.push_back(mk(8'h12, 2));
    q.push_back(mk(8'h20, 0));
    fork
      begin
        send(0, 8'h10, 1'b1, 1'b1);
        send(0, 8'h20, 1'b1, 1'b0);
      end
      send(1, 8'h11, 1'b1, 1'b0);
      send(2, 8'h12, 1'b1, 1'b0);
    join
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    bit ok;
    int t0;
    q.push_back(mk(8'h41, 0));
    q.push_back(mk(8'h42, 0));
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h41;
    req_last[0] = 1'b1;
    wait_ready(0, ok);
    t0 = cyc;
    checks++;
    if (uart_wr !== 1'b1 || req_ready !== 4'b0001 || tx_data !== 8'h41 || locked !== 1'b0 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL single_accept: wr=%b rdy=%b data=%h locked=%b grant=%b, required 1 0001 41 0 0001",
               uart_wr, req_ready, tx_data, locked, grant);
    end
    req_data[7:0] = 8'h42;
    wait_ready(0, ok);
    req_valid[0] = 1'b0;
    checks++;
    if (cyc - t0 !== G + 1) begin
      errors++;
      $display("FAIL single_spacing: gap=%0d cycles, required %0d", cyc - t0, G + 1);
    end
    @(negedge clk);
    checks++;
    if (uart_wr !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL single_pulse: wr=%b rdy=%b grant=%b, required 0 0000 0001", uart_wr, req_ready, grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_release: grant=%b, required 0000", grant);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_packet_lock();
    q.push_back(mk(8'h41, 1));
    q.push_back(mk(8'h42, 1));
    q.push_back(mk(8'h43, 1));
    q.push_back(mk(8'h30, 0));
    fork
      send(0, 8'h30, 1'b1, 1'b0);
      begin
        bit ok;
        for (int k = 0; k < 3; k++) begin
          req_valid[1] = 1'b1;
          req_data[15:8] = 8'h41 + 8'(k);
          req_last[1] = (k == 2);
          wait_ready(1, ok);
          checks++;
          if (grant !== 4'b0010 || locked !== (k != 2)) begin
            errors++;
            $display("FAIL packet_lock%0d: grant=%b locked=%b, required 0010 %b", k, grant, locked, k != 2);
          end
        end
        req_valid[1] = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
  endtask

  task automatic test_busy_stall();
    int seen = 0;
    q.push_back(mk(8'h5a, 0));
    tx_busy = 1'b1;
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h5a;
    req_last[0] = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (uart_wr || req_ready != '0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL busy_stall: %0d strobe cycles while busy, required 0", seen);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (uart_wr !== 1'b1 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL busy_release: wr=%b rdy=%b one cycle after busy fell, required 1 0001", uart_wr, req_ready);
    end
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int t0, t_err = -1, t3 = -1, n_err = 0;
    q.push_back(mk(8'h77, 2));
    q.push_back(mk(8'h88, 3));
    req_valid[3:2] = 2'b11;
    req_data[31:16] = 16'h8877;
    req_last[3:2] = 2'b10;
    wait_ready(2, ok);
    t0 = cyc;
    req_valid[2] = 1'b0;
    checks++;
    if (locked !== 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_lock: locked=%b grant=%b, required 1 0100", locked, grant);
    end
    repeat (30) begin
      @(negedge clk);
      if (timeout_err) begin
        n_err++;
        t_err = cyc;
        checks++;
        if (locked !== 1'b0 || grant !== 4'b0000) begin
          errors++;
          $display("FAIL timeout_drop: locked=%b grant=%b, required 0 0000", locked, grant);
        end
      end
      if (req_ready[3]) begin
        t3 = cyc;
        req_valid[3] = 1'b0;
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL timeout_next_lock: locked=%b, required 0", locked);
        end
      end
    end
    checks++;
    if (n_err != 1 || t_err - t0 != G + TO + 1 || t3 - t_err != 1) begin
      errors++;
      $display("FAIL timeout_timing: pulses=%0d err_at=+%0d req3_at=+%0d, required 1 +%0d +%0d",
               n_err, t_err - t0, t3 - t0, G + TO + 1, G + TO + 2);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    q.push_back(mk(8'h55, 2));
    send(2, 8'h55, 1'b1, 1'b0);
    q.push_back(mk(8'h66, 1));
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'h66;
    req_last[1] = 1'b0;
    wait_ready(1, ok);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL mid_locked: locked=%b, required 1", locked);
    end
    reset = 1'b1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({uart_wr, req_ready, tx_data, grant, locked, timeout_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: wr=%b rdy=%b data=%h grant=%b locked=%b to=%b, required all 0",
               uart_wr, req_ready, tx_data, grant, locked, timeout_err);
    end
    q.push_back(mk(8'h01, 0));
    q.push_back(mk(8'h03, 3));
    fork
      send(0, 8'h01, 1'b1, 1'b0);
      send(3, 8'h03, 1'b1, 1'b0);
    join
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_round_robin();
    test_single_byte();
    test_packet_lock();
    test_busy_stall();
    test_timeout();
    test_reset_mid_packet();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bytes never sent, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one buart transmitter among NUM_REQ byte-stream requesters, e.g. the loopback echo path, a status reporter and a debug dumper.
- Arbitration is round-robin with packet locking. A requester that starts a multi-byte packet keeps the transmitter until it sends its last byte or goes silent past a timeout.
- Drives buart wr/tx_data and watches buart busy. Sits between the requesters and the buart instance in each top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GUARD_CYCLES, 2, cycles after a wr pulse before busy is sampled again (min 1); covers buart busy-assert latency.
- TIMEOUT, 65535, idle cycles a locked owner may stall before its lock is dropped; 0 disables the timeout.

Ports:
- clk  in  1  system clock (clk_60mhz in tops).
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  8*NUM_REQ  byte for requester i, at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the last of its packet.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- tx_busy  in  1  buart busy.
- uart_wr  out  1  buart write strobe, one-cycle pulse.
- tx_data  out  8  buart tx_data; holds the last accepted byte.
- grant  out  NUM_REQ  one-hot current owner, else 0.
- locked  out  1  owner is mid-packet.
- timeout_err  out  1  one-cycle pulse when a lock is dropped by timeout.

Behaviour:
- Reset values: uart_wr=0, req_ready=0, tx_data=0, grant=0, locked=0, timeout_err=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 has first priority), counters=0. All outputs are registered.
- States: IDLE, GUARD.
- IDLE decision (cycle T):
  - Candidate set is {owner} if locked, else all i with req_valid[i].
  - Requires tx_busy=0 and a non-empty set.
  - Winner = first valid index searching upward from ptr+1, with wrap.
- Edge ending T:
  - uart_wr<=1; req_ready[w]<=1; tx_data<=req_data[w]; grant<=onehot(w).
  - locked<=~req_last[w]; if req_last[w], ptr<=w.
  - state<=GUARD; guard count<=GUARD_CYCLES-1.
- Requester rule: hold valid/data/last stable from assertion until the cycle req_ready is seen high. Data is captured at the decision edge.
- GUARD:
  - uart_wr and req_ready return to 0 the cycle after their pulse.
  - Count decrements each cycle; at 0, state<=IDLE.
  - grant stays set through GUARD. On return to IDLE, grant is cleared if not locked.
- Max throughput: one byte per (GUARD_CYCLES+1) cycles, then gated by tx_busy.
- tx_busy high in IDLE: no decision and no counter effect except timeout (below).
- Timeout: in IDLE with locked=1 and req_valid[owner]=0, the idle counter increments; any accept clears it.
  - When the counter reaches TIMEOUT: locked<=0, grant<=0, ptr<=owner, timeout_err pulse for one cycle, counter<=0.
  - Other requesters are eligible on the next cycle.
- Simultaneous events:
  - Owner's last byte is accepted while others are valid: the next decision follows the rr order from the advanced ptr.
  - Owner's valid rises in the same cycle the timeout fires: the timeout wins and that byte is not accepted this cycle.
- Non-owner requests while locked are ignored; their valid may stay high indefinitely.
- Reset mid-operation:
  - All state clears next edge and a pending packet is abandoned.
  - A byte already in buart finishes on the wire; the first IDLE decision waits on tx_busy.
- Invalid states decode to IDLE.

Test Plan:
1. Single byte: req_valid=0001, data 0x41, last=1, tx_busy=0 -> req_ready=0001 and uart_wr for one cycle in the same cycle, tx_data=0x41, locked stays 0, next decision no earlier than 3 cycles later (GUARD_CYCLES=2).
2. Round-robin: requesters 0,1,2 each present one byte (0x10, 0x11, 0x12) held, last=1 -> transmit order 0x10, 0x11, 0x12, one uart_wr per byte. Repeat with a fresh byte from requester 0 after 2 -> requester 0 served after 2, not before.
3. Packet lock: req1 sends "ABC" (last on C) while req0 holds 0x30 valid throughout -> tx order A, B, C, 0x30; locked=1 from after A until C accepted; grant=0010 throughout.
4. Busy stall: hold tx_busy=1 for 500 cycles with req0 valid -> no uart_wr or ready during the stall; accept within 1 cycle of busy falling.
5. Timeout (TIMEOUT=8): req2 sends one byte with last=0, then drops valid; req3 valid -> timeout_err pulses exactly once, 8 IDLE cycles after lock; req3 accepted next; locked=0.
6. Reset mid-packet: assert reset for 1 cycle while locked and in GUARD -> next cycle all outputs 0, ptr reset, req0 wins the next contention over req3.
